// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the radix-2 FFT stage sequencer.
// The UNLOAD state and bitrev helper serve the FFT_BITREV_EN build.
package fft_ctrl_pkg;

  localparam int STAGE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    UNLOAD,
    DONE
  } state_t;

  // Reverses the low i_width bits of i_val; bits above i_width come back as zero.
  function automatic logic [15:0] bitrev(input logic [15:0] i_val, input int i_width);
    logic [15:0] r_rev;
    r_rev = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < i_width) r_rev[i] = i_val[i_width-1-i];
    end
    return r_rev;
  endfunction

endpackage

// File: rtl/fft_addr_gen.sv
// Combinational butterfly address generator: (stage, butterfly count) ->
// read address pair and twiddle ROM index for an in-place radix-2 FFT.
module fft_addr_gen
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2 = 4,
  parameter int ADDR_W = N_LOG2
) (
  input  logic [STAGE_W-1:0] i_stage,
  input  logic [ADDR_W-1:0]  i_cnt,
  output logic [ADDR_W-1:0]  o_addr_a,
  output logic [ADDR_W-1:0]  o_addr_b,
  output logic [ADDR_W-2:0]  o_tw_addr
);

  logic [STAGE_W-1:0] w_sm1;
  logic [STAGE_W-1:0] w_twShift;
  logic [ADDR_W-1:0]  w_half;
  logic [ADDR_W-1:0]  w_low;
  logic [ADDR_W-1:0]  w_addrA;

  // Stage 0 only appears outside RUN; clamp it so the shifts stay sane.
  always_comb begin
    w_sm1     = (i_stage == '0) ? '0 : i_stage - STAGE_W'(1);
    w_half    = ADDR_W'(1) << w_sm1;
    w_low     = i_cnt & (w_half - ADDR_W'(1));
    w_addrA   = ((i_cnt >> w_sm1) << (w_sm1 + STAGE_W'(1))) | w_low;
    w_twShift = STAGE_W'(N_LOG2) - w_sm1 - STAGE_W'(1);
    o_addr_a  = w_addrA;
    o_addr_b  = w_addrA + w_half;
    o_tw_addr = w_low[ADDR_W-2:0] << w_twShift;
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 in-place FFT control sequencer: stage/butterfly FSM, registered
// read addresses and a PIPE_LAT-deep write-back delay line. Optional
// bit-reversed unload phase is enabled by defining FFT_BITREV_EN.
module fft_stage_sequencer
  import fft_ctrl_pkg::*;
#(
  parameter int N_LOG2   = 4,
  parameter int PIPE_LAT = 1,
  parameter int ADDR_W   = N_LOG2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  output logic [STAGE_W-1:0] o_stage_FFT,
  output logic               o_en,
  output logic               o_delay,
  output logic [ADDR_W-1:0]  o_addr_a,
  output logic [ADDR_W-1:0]  o_addr_b,
  output logic [ADDR_W-2:0]  o_tw_addr,
  output logic               o_wr_en,
  output logic [ADDR_W-1:0]  o_wr_addr_a,
  output logic [ADDR_W-1:0]  o_wr_addr_b,
`ifdef FFT_BITREV_EN
  output logic               o_out_valid,
  output logic [ADDR_W-1:0]  o_rd_addr,
`endif
  output logic               o_busy,
  output logic               o_done
);

  localparam int N    = 1 << N_LOG2;
  localparam int HALF = N / 2;
  localparam int DW   = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  state_t             r_state, w_stateNext;
  logic [ADDR_W-1:0]  r_cnt, w_cntNext;
  logic [STAGE_W-1:0] r_stage, w_stageNext;
  logic [DW-1:0]      r_drain, w_drainNext;

  logic [ADDR_W-1:0]  w_genA, w_genB;
  logic [ADDR_W-2:0]  w_genTw;

  logic [STAGE_W-1:0] r_stageOut;
  logic               r_en, r_delay, r_busy, r_done;
  logic [ADDR_W-1:0]  r_addrA, r_addrB;
  logic [ADDR_W-2:0]  r_twAddr;

  logic [PIPE_LAT-1:0] r_wrEnSr;
  logic [ADDR_W-1:0]   r_wrASr [PIPE_LAT];
  logic [ADDR_W-1:0]   r_wrBSr [PIPE_LAT];

  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_stageNext = r_stage;
    w_drainNext = r_drain;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_stateNext = RUN;
          w_cntNext   = '0;
          w_stageNext = STAGE_W'(1);
        end
      end
      RUN: begin
        if (r_cnt == ADDR_W'(HALF - 1)) begin
          w_stateNext = DRAIN;
          w_drainNext = '0;
        end else begin
          w_cntNext = r_cnt + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (r_drain == DW'(PIPE_LAT - 1)) begin
          if (r_stage < STAGE_W'(N_LOG2)) begin
            w_stateNext = RUN;
            w_stageNext = r_stage + STAGE_W'(1);
            w_cntNext   = '0;
          end else begin
`ifdef FFT_BITREV_EN
            w_stateNext = UNLOAD;
            w_cntNext   = '0;
`else
            w_stateNext = DONE;
`endif
          end
        end else begin
          w_drainNext = r_drain + DW'(1);
        end
      end
      UNLOAD: begin
        if (r_cnt == ADDR_W'(N - 1)) w_stateNext = DONE;
        else                         w_cntNext   = r_cnt + ADDR_W'(1);
      end
      DONE: begin
        w_stateNext = IDLE;
        w_stageNext = '0;
        w_cntNext   = '0;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  fft_addr_gen #(.N_LOG2(N_LOG2), .ADDR_W(ADDR_W)) u_addr_gen (
    .i_stage   (w_stageNext),
    .i_cnt     (w_cntNext),
    .o_addr_a  (w_genA),
    .o_addr_b  (w_genB),
    .o_tw_addr (w_genTw)
  );

  // Outputs are decoded from the next state so they are registered yet
  // line up with the state they describe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_stage    <= '0;
      r_drain    <= '0;
      r_stageOut <= '0;
      r_en       <= 1'b0;
      r_delay    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_addrA    <= '0;
      r_addrB    <= '0;
      r_twAddr   <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_cnt      <= w_cntNext;
      r_stage    <= w_stageNext;
      r_drain    <= w_drainNext;
      r_stageOut <= (w_stateNext == IDLE || w_stateNext == DONE) ? '0 : w_stageNext;
      r_en       <= (w_stateNext == RUN);
      r_delay    <= (w_stateNext == DRAIN);
      r_busy     <= (w_stateNext != IDLE);
      r_done     <= (w_stateNext == DONE);
      r_addrA    <= (w_stateNext == RUN) ? w_genA  : '0;
      r_addrB    <= (w_stateNext == RUN) ? w_genB  : '0;
      r_twAddr   <= (w_stateNext == RUN) ? w_genTw : '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wrEnSr <= '0;
      for (int i = 0; i < PIPE_LAT; i++) begin
        r_wrASr[i] <= '0;
        r_wrBSr[i] <= '0;
      end
    end else begin
      r_wrEnSr[0] <= r_en;
      r_wrASr[0]  <= r_addrA;
      r_wrBSr[0]  <= r_addrB;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_wrEnSr[i] <= r_wrEnSr[i-1];
        r_wrASr[i]  <= r_wrASr[i-1];
        r_wrBSr[i]  <= r_wrBSr[i-1];
      end
    end
  end

`ifdef FFT_BITREV_EN
  logic              r_outValid;
  logic [ADDR_W-1:0] r_rdAddr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_outValid <= 1'b0;
      r_rdAddr   <= '0;
    end else begin
      r_outValid <= (w_stateNext == UNLOAD);
      r_rdAddr   <= (w_stateNext == UNLOAD) ? ADDR_W'(bitrev(16'(w_cntNext), ADDR_W)) : '0;
    end
  end

  assign o_out_valid = r_outValid;
  assign o_rd_addr   = r_rdAddr;
`endif

  assign o_stage_FFT = r_stageOut;
  assign o_en        = r_en;
  assign o_delay     = r_delay;
  assign o_addr_a    = r_addrA;
  assign o_addr_b    = r_addrB;
  assign o_tw_addr   = r_twAddr;
  assign o_wr_en     = r_wrEnSr[PIPE_LAT-1];
  assign o_wr_addr_a = r_wrASr[PIPE_LAT-1];
  assign o_wr_addr_b = r_wrBSr[PIPE_LAT-1];
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule

// File: doc/fft_stage_sequencer.md
# fft_stage_sequencer

Control sequencer for the radix-2 in-place FFT butterfly datapath. On `start` it steps `stage_FFT` from 1 to `N_LOG2` and issues N/2 butterflies per stage. For each butterfly it generates the read address pair, the twiddle index and `en`, then asserts `delay` while the pipeline drains. It sits between the sample RAM and the butterfly adder/multiplier, and owns write-back address timing.

## Interface
Parameters:
- `N_LOG2`, 4: log2 of FFT length N; range 2..15, so `stage_FFT` fits 4 bits.
- `PIPE_LAT`, 1: butterfly datapath latency in cycles, from read address to write-back; must be >= 1.
- `ADDR_W`, `N_LOG2`: sample address width.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a transform; honoured only in IDLE.
- `stage_FFT`  out  4  current stage, 1..N_LOG2; 0 in IDLE/DONE.
- `en`  out  1  butterfly issue strobe, high during RUN.
- `delay`  out  1  drain strobe, high during DRAIN.
- `addr_a`, `addr_b`  out  ADDR_W  butterfly read addresses.
- `tw_addr`  out  ADDR_W-1  twiddle ROM index.
- `wr_en`  out  1  write-back strobe; `en` delayed by PIPE_LAT.
- `wr_addr_a`, `wr_addr_b`  out  ADDR_W  read addresses delayed by PIPE_LAT.
- `out_valid`  out  1  unload strobe; only exists with FFT_BITREV_EN.
- `rd_addr`  out  ADDR_W  unload address; only exists with FFT_BITREV_EN.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, RUN, DRAIN, UNLOAD (only with FFT_BITREV_EN), DONE.
- IDLE -> RUN when `start`=1. On entry: `stage_FFT`=1 and butterfly counter `cnt`=0.
- RUN: `en`=1 and `cnt` increments each cycle. After `cnt`=N/2-1, go to DRAIN.
- DRAIN: lasts exactly PIPE_LAT cycles with `delay`=1 and `en`=0.
- On DRAIN exit:
  - If `stage_FFT` < N_LOG2: increment `stage_FFT`, clear `cnt`, go to RUN.
  - Otherwise: go to UNLOAD if FFT_BITREV_EN is defined, else DONE.
- DONE: lasts one cycle with `done`=1, then IDLE.
- Address arithmetic, for stage s and half-span h = 2^(s-1):
  - `addr_a` = ((cnt >> (s-1)) << s) | (cnt & (h-1)).
  - `addr_b` = `addr_a` + h.
  - `tw_addr` = (cnt & (h-1)) << (N_LOG2-s).
  - All arithmetic is unsigned with no wrap: `addr_b` <= N-1 by construction.
- Write-back: `wr_en`, `wr_addr_a` and `wr_addr_b` come from a PIPE_LAT-deep shift register. The last write of each stage therefore lands in the final DRAIN cycle, before the next stage's first read.
- `start` while `busy`=1 is ignored; it is not queued.
- Reset, including mid-transform: IDLE immediately, with all outputs 0, `cnt`=0, and the delay line cleared.

## Timing
- With `start` sampled at edge 0 and PIPE_LAT=P:
  - stage s has `en` high for cycles (s-1)(N/2+P)+1 through (s-1)(N/2+P)+N/2;
  - `delay` is high for the following P cycles.
- `done` cycle = N_LOG2·(N/2+P)+1, plus N when FFT_BITREV_EN is defined.
- Outputs are registered: address, `en` and `delay` change only on clock edges.
- `stage_FFT` updates in the same cycle as the first `en` of the new stage.
- There are no idle bubbles between DRAIN and RUN.

## Configuration
- FFT_BITREV_EN defined:
  - An UNLOAD state runs N cycles with `out_valid`=1 and `rd_addr` = bit-reverse(`cnt`) over ADDR_W bits, `cnt` counting 0..N-1.
  - Then DONE.
- FFT_BITREV_EN undefined:
  - No UNLOAD state; DRAIN of the last stage goes straight to DONE.
  - `out_valid` and `rd_addr` ports are absent.

## Structure
- Package `fft_ctrl_pkg` holds:
  - the state enum;
  - the `bitrev` function, parameterised by width;
  - the constant `STAGE_W`=4.
- Sub-module `fft_addr_gen` is purely combinational: it maps (`stage_FFT`, `cnt`) to (`addr_a`, `addr_b`, `tw_addr`).
- The sequencer registers the outputs of `fft_addr_gen` and owns the FSM, the counters and the delay line.

## Test plan
All scenarios use N_LOG2=4, P=1 unless stated.
- Reset then `start` at edge 0 -> `en` high cycles 1–8, `delay` cycle 9, `stage_FFT` 1→2 at cycle 10, `done` at cycle 37 (53 with FFT_BITREV_EN).
- Stage 1 addresses -> pairs (0,1),(2,3)…(14,15), `tw_addr`=0 throughout. Stage 4 -> pairs (0,8)…(7,15), `tw_addr` 0..7.
- P=3 -> `wr_en` equals `en` shifted 3 cycles, `wr_addr_a` matches `addr_a` from 3 cycles earlier, `delay` high 3 cycles per stage.
- `start` pulsed at cycle 5 during a transform -> no effect, single `done` at cycle 37.
- `rst_n` low at cycle 20 -> all outputs 0 asynchronously. A new `start` after release gives the full nominal sequence from stage 1.
- FFT_BITREV_EN -> `rd_addr` sequence 0,8,4,12,2,10,…,15 with `out_valid` high for 16 cycles, then `done`.
